// File: rtl/bank_session_ctrl.sv
// SIM/biometric/PIN login sequencer with retry lockout, per-stage inactivity timeout,
// and a single-cycle balance/withdraw/deposit/logout transaction port.
module bank_session_ctrl #(
    parameter int                 PIN_W        = 16,
    parameter int                 BAL_W        = 16,
    parameter logic [PIN_W-1:0]   STORED_PIN   = 16'h4321,
    parameter int                 INIT_BALANCE = 8000,
    parameter int                 MAX_TRIES    = 3,
    parameter int                 TIMEOUT_CYC  = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sim_sms_received,
    input  logic                             face_verified,
    input  logic                             pin_strobe,
    input  logic [PIN_W-1:0]                 user_pin,
    input  logic                             txn_valid,
    input  logic [1:0]                       txn_op,
    input  logic [BAL_W-1:0]                 txn_amount,
    output logic                             txn_ready,
    output logic                             txn_done,
    output logic                             txn_err,
    output logic [BAL_W-1:0]                 balance,
    output logic                             access_granted,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int FC_W = $clog2(MAX_TRIES + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_QUERY    = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_LOGOUT   = 2'b11;

    // One-hot so every status output is a flop bit with no decode behind it.
    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_WAIT_FACE = 5'b00010,
        S_WAIT_PIN  = 5'b00100,
        S_SESSION   = 5'b01000,
        S_LOCKED    = 5'b10000
    } state_t;

    state_t             state, state_nxt;
    logic [TM_W-1:0]    timer, timer_nxt;
    logic [FC_W-1:0]    fail_nxt;
    logic [BAL_W-1:0]   bal_nxt;
    logic               err_nxt;
    logic               txn_accept;
    logic               clear_evt;
    logic               timed;
    logic               timeout;
    logic [BAL_W:0]     sum_w;
    logic [BAL_W:0]     dif_w;

    // MSB of the widened result is the carry (add) or borrow (subtract).
    function automatic logic [BAL_W:0] add_chk(input logic [BAL_W-1:0] a, input logic [BAL_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [BAL_W:0] sub_chk(input logic [BAL_W-1:0] a, input logic [BAL_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    always_comb begin
        txn_accept = (state == S_SESSION) && txn_valid;
        clear_evt  = pin_strobe || txn_accept;
        timed      = (state == S_WAIT_FACE) || (state == S_WAIT_PIN) || (state == S_SESSION);
        timeout    = timed && !clear_evt && (timer == TM_W'(TIMEOUT_CYC - 1));
    end

    // Transaction datapath: rejected requests leave the balance untouched.
    always_comb begin
        sum_w   = add_chk(balance, txn_amount);
        dif_w   = sub_chk(balance, txn_amount);
        bal_nxt = balance;
        err_nxt = 1'b0;
        if (txn_accept) begin
            case (txn_op)
                OP_WITHDRAW: begin
                    if (dif_w[BAL_W]) err_nxt = 1'b1;
                    else              bal_nxt = dif_w[BAL_W-1:0];
                end
                OP_DEPOSIT: begin
                    if (sum_w[BAL_W]) err_nxt = 1'b1;
                    else              bal_nxt = sum_w[BAL_W-1:0];
                end
                OP_QUERY, OP_LOGOUT: begin
                    bal_nxt = balance;
                end
                default: bal_nxt = balance;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_count;
        case (state)
            S_IDLE: begin
                if (sim_sms_received) state_nxt = S_WAIT_FACE;
            end
            S_WAIT_FACE: begin
                if (face_verified) state_nxt = S_WAIT_PIN;
                else if (timeout)  state_nxt = S_IDLE;
            end
            S_WAIT_PIN: begin
                if (pin_strobe) begin
                    if (user_pin == STORED_PIN) begin
                        state_nxt = S_SESSION;
                        fail_nxt  = '0;
                    end else begin
                        fail_nxt = fail_count + 1'b1;
                        if (fail_count == FC_W'(MAX_TRIES - 1)) state_nxt = S_LOCKED;
                    end
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SESSION: begin
                if (txn_accept && (txn_op == OP_LOGOUT)) state_nxt = S_IDLE;
                else if (timeout)                        state_nxt = S_IDLE;
            end
            S_LOCKED: state_nxt = S_LOCKED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        access_granted = state[3];
        txn_ready      = state[3];
        locked_out     = state[4];
    end

    // Timer restarts on any state change or user activity; it idles at zero elsewhere.
    always_comb begin
        if (!timed || clear_evt || (state_nxt != state)) timer_nxt = '0;
        else                                             timer_nxt = timer + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            fail_count <= '0;
            balance    <= BAL_W'(INIT_BALANCE);
            txn_done   <= 1'b0;
            txn_err    <= 1'b0;
        end else begin
            timer      <= timer_nxt;
            fail_count <= fail_nxt;
            balance    <= bal_nxt;
            txn_done   <= txn_accept;
            txn_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bank_session_ctrl.sv
// Bench for bank_session_ctrl: vector table for the transaction port plus login,
// lockout, timeout and asynchronous-reset sequences, with a completion scoreboard.
module tb_bank_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sim_sms_received;
    logic        face_verified;
    logic        pin_strobe;
    logic [15:0] user_pin;
    logic        txn_valid;
    logic [1:0]  txn_op;
    logic [15:0] txn_amount;
    logic        txn_ready;
    logic        txn_done;
    logic        txn_err;
    logic [15:0] balance;
    logic        access_granted;
    logic        locked_out;
    logic [1:0]  fail_count;

    bank_session_ctrl #(
        .PIN_W(16), .BAL_W(16), .STORED_PIN(16'h4321), .INIT_BALANCE(8000),
        .MAX_TRIES(3), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst),
        .sim_sms_received(sim_sms_received), .face_verified(face_verified),
        .pin_strobe(pin_strobe), .user_pin(user_pin),
        .txn_valid(txn_valid), .txn_op(txn_op), .txn_amount(txn_amount),
        .txn_ready(txn_ready), .txn_done(txn_done), .txn_err(txn_err),
        .balance(balance), .access_granted(access_granted),
        .locked_out(locked_out), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] amt;
        logic        err;
        logic [15:0] bal;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [15:0] bal;
    } exp_t;

    vec_t vecs[13];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (txn_done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got txn_done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.due));
                chk("txn_err", 32'(txn_err), 32'(e.err));
                chk("balance", 32'(balance), 32'(e.bal));
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_done: got txn_done=0 expected 1 (cycle %0d)", cyc);
            e = sbq.pop_front();
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [15:0] amt,
                       input logic err, input logic [15:0] bal);
        txn_valid  = 1'b1;
        txn_op     = op;
        txn_amount = amt;
        sbq.push_back('{cyc + 1, err, bal});
        tick();
        txn_valid  = 1'b0;
    endtask

    task automatic pin(input logic [15:0] p);
        user_pin   = p;
        pin_strobe = 1'b1;
        tick();
        pin_strobe = 1'b0;
    endtask

    task automatic sms();
        sim_sms_received = 1'b1;
        tick();
        sim_sms_received = 1'b0;
    endtask

    task automatic face();
        face_verified = 1'b1;
        tick();
        face_verified = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 16'd0,     1'b0, 16'd8000};
        vecs[1]  = '{2'b01, 16'd9000,  1'b1, 16'd8000};
        vecs[2]  = '{2'b10, 16'd65535, 1'b1, 16'd8000};
        vecs[3]  = '{2'b01, 16'd3000,  1'b0, 16'd5000};
        vecs[4]  = '{2'b10, 16'd500,   1'b0, 16'd5500};
        vecs[5]  = '{2'b01, 16'd0,     1'b0, 16'd5500};
        vecs[6]  = '{2'b10, 16'd0,     1'b0, 16'd5500};
        vecs[7]  = '{2'b01, 16'd5500,  1'b0, 16'd0};
        vecs[8]  = '{2'b01, 16'd1,     1'b1, 16'd0};
        vecs[9]  = '{2'b10, 16'd65535, 1'b0, 16'd65535};
        vecs[10] = '{2'b10, 16'd1,     1'b1, 16'd65535};
        vecs[11] = '{2'b01, 16'd60035, 1'b0, 16'd5500};
        vecs[12] = '{2'b00, 16'd0,     1'b0, 16'd5500};

        rst = 1'b1;
        sim_sms_received = 1'b0;
        face_verified = 1'b0;
        pin_strobe = 1'b0;
        user_pin = '0;
        txn_valid = 1'b0;
        txn_op = '0;
        txn_amount = '0;
        #22;
        chk("rst_access", 32'(access_granted), 0);
        chk("rst_ready", 32'(txn_ready), 0);
        chk("rst_locked", 32'(locked_out), 0);
        chk("rst_done", 32'(txn_done), 0);
        chk("rst_err", 32'(txn_err), 0);
        chk("rst_balance", 32'(balance), 8000);
        chk("rst_fail", 32'(fail_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Happy path; a PIN while still waiting for the face is ignored.
        sms();
        pin(16'h4321);
        chk("pin_before_face", 32'(access_granted), 0);
        face();
        pin(16'h4321);
        chk("login_access", 32'(access_granted), 1);
        chk("login_ready", 32'(txn_ready), 1);

        for (int i = 0; i < 13; i++) txn(vecs[i].op, vecs[i].amt, vecs[i].err, vecs[i].bal);

        txn(2'b11, 16'd0, 1'b0, 16'd5500);
        chk("logout_access", 32'(access_granted), 0);
        chk("logout_ready", 32'(txn_ready), 0);
        txn_valid = 1'b1;
        txn_op = 2'b00;
        tick();
        txn_valid = 1'b0;
        tick();

        // Balance survives logout; then an idle session expires.
        sms();
        face();
        pin(16'h4321);
        txn(2'b00, 16'd0, 1'b0, 16'd5500);
        repeat (7) tick();
        chk("session_idle7", 32'(access_granted), 1);
        tick();
        chk("session_timeout", 32'(access_granted), 0);

        // Lockout after three wrong PINs.
        sms();
        face();
        pin(16'h1111);
        chk("fail1", 32'(fail_count), 1);
        chk("fail1_locked", 32'(locked_out), 0);
        pin(16'h1111);
        chk("fail2", 32'(fail_count), 2);
        pin(16'h1111);
        chk("fail3", 32'(fail_count), 3);
        chk("locked", 32'(locked_out), 1);
        pin(16'h4321);
        chk("locked_pin_ignored", 32'(access_granted), 0);
        sms();
        chk("locked_sticky", 32'(locked_out), 1);
        rst = 1'b1;
        #1;
        chk("unlock_locked", 32'(locked_out), 0);
        chk("unlock_fail", 32'(fail_count), 0);
        chk("unlock_balance", 32'(balance), 8000);
        #2;
        rst = 1'b0;
        tick();

        // PIN arriving on the timeout cycle wins; one cycle later it is too late.
        sms();
        face();
        repeat (7) tick();
        pin(16'h4321);
        chk("pin_at_timeout", 32'(access_granted), 1);
        txn(2'b11, 16'd0, 1'b0, 16'd8000);
        sms();
        face();
        repeat (8) tick();
        pin(16'h4321);
        chk("pin_after_timeout", 32'(access_granted), 0);

        // Wrong-PIN count is kept across a timeout.
        sms();
        face();
        pin(16'h1111);
        repeat (9) tick();
        pin(16'h4321);
        chk("idle_after_timeout", 32'(access_granted), 0);
        chk("fail_retained", 32'(fail_count), 1);

        // Asynchronous reset in the middle of a transaction.
        sms();
        face();
        pin(16'h4321);
        chk("relogin_fail_clear", 32'(fail_count), 0);
        txn(2'b01, 16'd1000, 1'b0, 16'd7000);
        txn_valid = 1'b1;
        txn_op = 2'b01;
        txn_amount = 16'd500;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_done", 32'(txn_done), 0);
        chk("arst_access", 32'(access_granted), 0);
        chk("arst_ready", 32'(txn_ready), 0);
        chk("arst_balance", 32'(balance), 8000);
        txn_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        tick();

        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
